dmi_debug_regs: RTL
===================

Name: dmi_debug_regs

Overview:
- APB slave directly downstream of the JTAG DMI bridge; terminates every DMI access in the clk_i domain.
- Implements the minimal RISC-V debug-module register set: dmcontrol, dmstatus, abstractcs, command and a 33-bit data0 (bit 32 = CHERI tag).
- Sequences abstract register-access commands to the core over a req/ack handshake and drives haltreq/resumereq/ndmreset.

Parameters:
- DMI_ADDR_BITS, 7, DMI address width.
- DMI_DATA_BITS, 33, DMI data width (32 data + tag).
- DM_VERSION, 4'h2, dmstatus.version field.

Ports:
- clk_i  in  1  system clock
- TRSTn_i  in  1  asynchronous active-low reset
- psel_dmi_i  in  1  APB select
- penable_dmi_i  in  1  APB enable
- paddr_dmi_i  in  DMI_ADDR_BITS  register address
- pwdata_dmi_i  in  DMI_DATA_BITS  write data
- pwrite_dmi_i  in  1  1=write
- prdata_dmi_o  out  DMI_DATA_BITS  read data
- pready_dmi_o  out  1  ready
- pslverr_dmi_o  out  1  error, tied 0
- halted_i  in  1  hart halted status
- haltreq_o  out  1  halt request
- resumereq_o  out  1  resume request
- ndmreset_o  out  1  non-debug-module reset
- dbg_req_o  out  1  abstract access request
- dbg_we_o  out  1  1=register write
- dbg_regno_o  out  16  register number
- dbg_wdata_o  out  DMI_DATA_BITS  write data to core
- dbg_ack_i  in  1  access complete, one-cycle pulse
- dbg_rdata_i  in  DMI_DATA_BITS  read data, valid with ack
- dbg_err_i  in  1  access faulted, valid with ack

Behaviour:
- Reset: all outputs 0. Internal state: data0=0, cmderr=0, FSM=IDLE, dmactive=0, resumeack=0.
- APB: zero wait state. pready_dmi_o = psel & penable. prdata is combinational from the register addressed during the access phase; it is 0 outside the access phase and for unmapped addresses. A write commits on the clk_i edge that ends the access phase. Unmapped writes are ignored.
- Register map:
  - 0x04 data0: read/write, 33 bits.
  - 0x10 dmcontrol: [31] haltreq, [30] resumereq (write-only, reads 0), [1] ndmreset, [0] dmactive.
  - 0x11 dmstatus (read-only): [17:16] resumeack ×2, [11:10] ~halted_i ×2, [9:8] halted_i ×2, [7]=1, [3:0]=DM_VERSION.
  - 0x16 abstractcs: [28:24]=0, [12] busy, [10:8] cmderr (write-1-to-clear per bit), [3:0]=1.
  - 0x17 command: write-only, reads 0.
- dmactive=0:
  - haltreq, resumereq, ndmreset, cmderr and data0 are held at 0.
  - Writes to anything other than dmcontrol are ignored.
  - An in-flight access is allowed to finish; its rdata is discarded.
- haltreq_o and ndmreset_o follow the dmcontrol bits. Bit 32 is don't-care on all non-data0 registers.
- Resume:
  - Writing resumereq=1 with haltreq=0 sets resumereq_o and clears resumeack.
  - resumereq_o stays high until a clk_i edge samples halted_i=0; that edge clears resumereq_o and sets resumeack.
  - If haltreq=1 in the same write, resumereq is ignored.
- Command word: [31:24] cmdtype, [22:20] aarsize, [17] transfer, [16] write, [15:0] regno.
- Command checks on a write to command, evaluated in priority order:
  1. busy → cmderr=1 (busy). Command dropped.
  2. cmderr≠0 → command ignored.
  3. cmdtype≠0 or aarsize≠2 → cmderr=2.
  4. halted_i=0 → cmderr=4.
  5. Otherwise accepted.
- Busy during an access: writes to data0 or abstractcs while busy also set cmderr=1, provided cmderr was 0; the write itself is dropped. Reading data0 while busy returns the stale value, cmderr unchanged.
- FSM IDLE→REQ→IDLE, busy = (FSM≠IDLE):
  - Accept with transfer=0: completes with no core access. busy never asserts; the command is a no-op.
  - Accept with transfer=1: the next cycle asserts dbg_req_o with dbg_we_o=write, dbg_regno_o=regno, dbg_wdata_o=data0, all held stable until dbg_ack_i.
  - On a dbg_ack_i cycle: dbg_req_o drops next cycle, FSM→IDLE.
  - If dbg_err_i: cmderr=3, data0 unchanged.
  - Else, if write=0: data0 ← dbg_rdata_i.
  - dbg_ack_i while IDLE is ignored.
- Simultaneous events:
  - A cmderr W1C in the same cycle as hardware setting cmderr: the hardware set wins.
  - Async TRSTn_i assertion mid-access drops dbg_req_o immediately; a later stray ack is ignored.

Test Plan:
- Write dmcontrol=0x8000_0001 → haltreq_o=1. Read dmstatus with halted_i=1 → 0x0000_0382.
- Halted; data0=0x1_DEAD_BEEF; command=0x0023_1008 → dbg_req_o=1, we=1, regno=0x1008, wdata=0x1_DEAD_BEEF. Ack after 3 cycles → abstractcs busy=0, cmderr=0.
- Command=0x0022_1001; core acks with rdata=0x0_1234_5678 → read data0 = 0x0_1234_5678.
- Write command while busy → cmderr=1. Following command ignored (no dbg_req_o). Write abstractcs 0x700 → cmderr=0.
- Command aarsize=3 → cmderr=2. Clear it. Command with halted_i=0 → cmderr=4. Clear it. Access acked with dbg_err_i=1 → cmderr=3, data0 unchanged.
- halted_i=1; write dmcontrol=0x4000_0001 → resumereq_o=1. Drop halted_i → resumereq_o=0 next edge, dmstatus[17:16]=2'b11. Then pulse TRSTn_i low mid-access → all outputs 0 immediately.

Source files
------------

// File: rtl/dmi_debug_regs.sv
// Minimal RISC-V debug-module register file behind the JTAG DMI bridge (APB slave).
// Sequences abstract register-access commands to the core over a req/ack handshake.
module dmi_debug_regs #(
  parameter int          DMI_ADDR_BITS = 7,
  parameter int          DMI_DATA_BITS = 33,
  parameter logic [3:0]  DM_VERSION    = 4'h2
) (
  input  logic                     clk_i,
  input  logic                     TRSTn_i,
  input  logic                     psel_dmi_i,
  input  logic                     penable_dmi_i,
  input  logic [DMI_ADDR_BITS-1:0] paddr_dmi_i,
  input  logic [DMI_DATA_BITS-1:0] pwdata_dmi_i,
  input  logic                     pwrite_dmi_i,
  output logic [DMI_DATA_BITS-1:0] prdata_dmi_o,
  output logic                     pready_dmi_o,
  output logic                     pslverr_dmi_o,
  input  logic                     halted_i,
  output logic                     haltreq_o,
  output logic                     resumereq_o,
  output logic                     ndmreset_o,
  output logic                     dbg_req_o,
  output logic                     dbg_we_o,
  output logic [15:0]              dbg_regno_o,
  output logic [DMI_DATA_BITS-1:0] dbg_wdata_o,
  input  logic                     dbg_ack_i,
  input  logic [DMI_DATA_BITS-1:0] dbg_rdata_i,
  input  logic                     dbg_err_i
);

  localparam logic [DMI_ADDR_BITS-1:0] A_DATA0      = DMI_ADDR_BITS'('h04);
  localparam logic [DMI_ADDR_BITS-1:0] A_DMCONTROL  = DMI_ADDR_BITS'('h10);
  localparam logic [DMI_ADDR_BITS-1:0] A_DMSTATUS   = DMI_ADDR_BITS'('h11);
  localparam logic [DMI_ADDR_BITS-1:0] A_ABSTRACTCS = DMI_ADDR_BITS'('h16);
  localparam logic [DMI_ADDR_BITS-1:0] A_COMMAND    = DMI_ADDR_BITS'('h17);

  typedef enum logic {S_IDLE, S_REQ} state_t;

  state_t                   state;
  logic                     dmactive, resumeack;
  logic [2:0]               cmderr;
  logic [DMI_DATA_BITS-1:0] data0;

  logic access, wr, busy, act_next;
  logic wr_ctl, wr_d0, wr_acs, wr_cmd;
  logic [7:0] cmdtype;
  logic [2:0] aarsize;
  logic [31:0] rd32;

  assign access        = psel_dmi_i & penable_dmi_i;
  assign wr            = access & pwrite_dmi_i;
  assign pready_dmi_o  = access;
  assign pslverr_dmi_o = 1'b0;
  assign busy          = (state != S_IDLE);

  // Everything except dmcontrol is frozen while the module is inactive.
  assign wr_ctl = wr && (paddr_dmi_i == A_DMCONTROL);
  assign wr_d0  = wr && dmactive && (paddr_dmi_i == A_DATA0);
  assign wr_acs = wr && dmactive && (paddr_dmi_i == A_ABSTRACTCS);
  assign wr_cmd = wr && dmactive && (paddr_dmi_i == A_COMMAND);

  assign act_next = wr_ctl ? pwdata_dmi_i[0] : dmactive;
  assign cmdtype  = pwdata_dmi_i[31:24];
  assign aarsize  = pwdata_dmi_i[22:20];

  always_comb begin
    rd32         = '0;
    prdata_dmi_o = '0;
    if (access) begin
      case (paddr_dmi_i)
        A_DMCONTROL:  rd32 = {haltreq_o, 29'b0, ndmreset_o, dmactive};
        A_DMSTATUS:   rd32 = {14'b0, resumeack, resumeack, 4'b0,
                              ~halted_i, ~halted_i, halted_i, halted_i,
                              1'b1, 3'b0, DM_VERSION};
        A_ABSTRACTCS: rd32 = {19'b0, busy, 1'b0, cmderr, 4'b0, 4'd1};
        default:      rd32 = '0;
      endcase
      if (paddr_dmi_i == A_DATA0) prdata_dmi_o = data0;
      else                        prdata_dmi_o = {{(DMI_DATA_BITS-32){1'b0}}, rd32};
    end
  end

  always_ff @(posedge clk_i or negedge TRSTn_i) begin
    if (!TRSTn_i) begin
      state       <= S_IDLE;
      dmactive    <= 1'b0;
      haltreq_o   <= 1'b0;
      ndmreset_o  <= 1'b0;
      resumereq_o <= 1'b0;
      resumeack   <= 1'b0;
      cmderr      <= '0;
      data0       <= '0;
      dbg_req_o   <= 1'b0;
      dbg_we_o    <= 1'b0;
      dbg_regno_o <= '0;
      dbg_wdata_o <= '0;
    end else begin
      if (wr_ctl) begin
        dmactive   <= pwdata_dmi_i[0];
        haltreq_o  <= pwdata_dmi_i[31] & pwdata_dmi_i[0];
        ndmreset_o <= pwdata_dmi_i[1] & pwdata_dmi_i[0];
      end

      // Resume: a halt request in the same write takes precedence.
      if (wr_ctl && !pwdata_dmi_i[0]) begin
        resumereq_o <= 1'b0;
      end else if (wr_ctl && pwdata_dmi_i[30] && !pwdata_dmi_i[31]) begin
        resumereq_o <= 1'b1;
        resumeack   <= 1'b0;
      end else if (resumereq_o && !halted_i) begin
        resumereq_o <= 1'b0;
        resumeack   <= 1'b1;
      end

      if ((wr_d0 || wr_acs) && busy) begin
        if (cmderr == 3'd0) cmderr <= 3'd1;
      end else begin
        if (wr_d0)  data0  <= pwdata_dmi_i;
        if (wr_acs) cmderr <= cmderr & ~pwdata_dmi_i[10:8];
      end

      if (wr_cmd) begin
        if (busy)                              cmderr <= 3'd1;
        else if (cmderr != 3'd0)               ;
        else if (cmdtype != 8'd0 || aarsize != 3'd2) cmderr <= 3'd2;
        else if (!halted_i)                    cmderr <= 3'd4;
        else if (pwdata_dmi_i[17]) begin
          state       <= S_REQ;
          dbg_req_o   <= 1'b1;
          dbg_we_o    <= pwdata_dmi_i[16];
          dbg_regno_o <= pwdata_dmi_i[15:0];
          dbg_wdata_o <= data0;
        end
      end

      // Completion: result discarded if the module was deactivated meanwhile.
      if (state == S_REQ && dbg_ack_i) begin
        state       <= S_IDLE;
        dbg_req_o   <= 1'b0;
        dbg_we_o    <= 1'b0;
        dbg_regno_o <= '0;
        dbg_wdata_o <= '0;
        if (act_next) begin
          if (dbg_err_i)     cmderr <= 3'd3;
          else if (!dbg_we_o) data0 <= dbg_rdata_i;
        end
      end

      if (!act_next) begin
        data0  <= '0;
        cmderr <= '0;
      end
    end
  end

endmodule
